// File: rtl/if_hazard_ctrl.sv
// rtl/if_hazard_ctrl.sv - fetch-stage pipeline sequencer for load-use, multiply and redirect hazards
module if_hazard_ctrl #(
    parameter int          MUL_LAT = 4,
    parameter logic [31:0] NOP     = 32'h5400_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:4]  id_rs1,
    input  logic [0:4]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_is_load,
    input  logic [0:4]  ex_rd,
    input  logic        ex_is_mul,
    input  logic        br_taken,
    input  logic [0:31] br_target,
    output logic        reg_lock,
    output logic        jump_or_branch,
    output logic [0:31] target,
    output logic        bubble_ex,
    output logic        ex_hold,
    output logic        flush_id
);

    typedef enum logic {ST_RUN, ST_MULBUSY} state_e;

    localparam logic [0:3] CNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

    state_e      st_q, st_d;
    logic [0:3]  cnt_q, cnt_d;
    logic        pend_v_q, pend_v_d;
    logic [0:31] pend_tgt_q, pend_tgt_d;
    logic        flush_q;

    logic ldu, run, redir, ldu_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_RUN;
            cnt_q      <= 4'd0;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= 32'd0;
            flush_q    <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
            flush_q    <= redir;
        end
    end

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        pend_v_d   = pend_v_q;
        pend_tgt_d = pend_tgt_q;

        ldu = ex_is_load && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
        run = (st_q == ST_RUN);
        // A redirect flushes the ID instruction, so it wins over a load-use stall.
        redir     = run && (pend_v_q || br_taken);
        ldu_stall = run && ldu && !redir;

        case (st_q)
            ST_RUN: begin
                if (ex_is_mul && (MUL_LAT > 1)) begin
                    st_d  = ST_MULBUSY;
                    cnt_d = CNT_INIT;
                end
            end
            ST_MULBUSY: begin
                if (cnt_q == 4'd0) st_d = ST_RUN;
                else               cnt_d = cnt_q - 4'd1;
            end
            default: st_d = ST_RUN;
        endcase

        // Only the oldest redirect is kept; later ones are on its wrong path.
        if (redir) begin
            pend_v_d = 1'b0;
        end else if (br_taken && !pend_v_q && (!run || ldu_stall)) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = br_target;
        end
    end

    assign reg_lock       = rst_n && (!run || ldu_stall);
    assign ex_hold        = rst_n && !run;
    assign bubble_ex      = rst_n && (redir || ldu_stall);
    assign jump_or_branch = rst_n && redir;
    assign target         = !rst_n ? 32'd0 : ((redir && pend_v_q) ? pend_tgt_q : br_target);
    assign flush_id       = rst_n && flush_q;

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// tb/tb_if_hazard_ctrl.sv - directed self-checking bench for if_hazard_ctrl
module tb_if_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:4]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_is_mul, br_taken;
    logic [0:31] br_target;
    logic        reg_lock, jump_or_branch, bubble_ex, ex_hold, flush_id;
    logic [0:31] target;
    logic        reg_lock1, jump_or_branch1, bubble_ex1, ex_hold1, flush_id1;
    logic [0:31] target1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_hazard_ctrl #(.MUL_LAT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_is_mul(ex_is_mul),
        .br_taken(br_taken), .br_target(br_target),
        .reg_lock(reg_lock), .jump_or_branch(jump_or_branch), .target(target),
        .bubble_ex(bubble_ex), .ex_hold(ex_hold), .flush_id(flush_id)
    );

    if_hazard_ctrl #(.MUL_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_is_mul(ex_is_mul),
        .br_taken(br_taken), .br_target(br_target),
        .reg_lock(reg_lock1), .jump_or_branch(jump_or_branch1), .target(target1),
        .bubble_ex(bubble_ex1), .ex_hold(ex_hold1), .flush_id(flush_id1)
    );

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_is_mul = 1'b0; br_taken = 1'b0;
        br_target = 32'h0000_0000;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        rst_n = 1'b0;
        idle_inputs();
        br_taken = 1'b1; br_target = 32'h0000_0abc; ex_is_load = 1'b1; ex_rd = 5'd3;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        #1;
        outs = {reg_lock, jump_or_branch, bubble_ex, ex_hold, flush_id, |target};
        checks++;
        if (outs !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 000000", outs);
        end
        repeat (2) @(posedge clk);
        next_cycle();
        rst_n = 1'b1;
        #1;
        outs = {reg_lock, jump_or_branch, bubble_ex, ex_hold, flush_id, 1'b0};
        checks++;
        if (outs !== 6'b0) begin
            errors++; $display("FAIL reset_release_idle: got %b want 000000", outs);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if ({reg_lock, bubble_ex, ex_hold, jump_or_branch} !== 4'b1100) begin
            errors++; $display("FAIL ldu_stall: got %b want 1100", {reg_lock, bubble_ex, ex_hold, jump_or_branch});
        end
        next_cycle();
        #1;
        checks++;
        if ({reg_lock, bubble_ex} !== 2'b00) begin
            errors++; $display("FAIL ldu_release: got %b want 00", {reg_lock, bubble_ex});
        end
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        #1;
        checks++;
        if ({reg_lock, bubble_ex} !== 2'b00) begin
            errors++; $display("FAIL ldu_rd_zero: got %b want 00", {reg_lock, bubble_ex});
        end
        ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0; id_rs2 = 5'd1;
        #1;
        checks++;
        if (reg_lock !== 1'b0) begin
            errors++; $display("FAIL ldu_unused_rs1: got %b want 0", reg_lock);
        end
    endtask

    task automatic test_mul();
        logic [1:0] exp_lh;
        next_cycle();
        ex_is_mul = 1'b1;
        #1;
        checks++;
        if ({reg_lock, ex_hold, reg_lock1} !== 3'b000) begin
            errors++; $display("FAIL mul_issue: got %b want 000", {reg_lock, ex_hold, reg_lock1});
        end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            ex_is_mul = (c == 2);
            #1;
            exp_lh = (c <= 3) ? 2'b11 : 2'b00;
            checks++;
            if ({reg_lock, ex_hold} !== exp_lh || bubble_ex !== 1'b0) begin
                errors++; $display("FAIL mul_cycle%0d: got lock/hold/bubble %b%b%b want %b0", c, reg_lock, ex_hold, bubble_ex, exp_lh);
            end
            checks++;
            if ({reg_lock1, ex_hold1} !== 2'b00) begin
                errors++; $display("FAIL mul_lat1_cycle%0d: got %b want 00", c, {reg_lock1, ex_hold1});
            end
        end
    endtask

    task automatic test_branch();
        next_cycle();
        br_taken = 1'b1; br_target = 32'h0000_0100;
        #1;
        checks++;
        if ({jump_or_branch, bubble_ex, reg_lock, flush_id} !== 4'b1100 || target !== 32'h0000_0100) begin
            errors++; $display("FAIL branch_t: got jb/bub/lock/fl %b tgt %h want 1100 tgt 00000100",
                               {jump_or_branch, bubble_ex, reg_lock, flush_id}, target);
        end
        next_cycle();
        #1;
        checks++;
        if ({flush_id, jump_or_branch, bubble_ex} !== 3'b100) begin
            errors++; $display("FAIL branch_t1: got fl/jb/bub %b want 100", {flush_id, jump_or_branch, bubble_ex});
        end
        next_cycle();
        #1;
        checks++;
        if (flush_id !== 1'b0) begin
            errors++; $display("FAIL branch_t2: got flush %b want 0", flush_id);
        end
    endtask

    task automatic test_buffered();
        next_cycle();
        ex_is_mul = 1'b1;
        next_cycle();
        next_cycle();
        br_taken = 1'b1; br_target = 32'h0000_0200;
        #1;
        checks++;
        if ({jump_or_branch, reg_lock} !== 2'b01 || target !== 32'h0000_0200) begin
            errors++; $display("FAIL buf_capture: got jb/lock %b tgt %h want 01 tgt 00000200", {jump_or_branch, reg_lock}, target);
        end
        next_cycle();
        br_taken = 1'b1; br_target = 32'h0000_0300;
        #1;
        checks++;
        if ({jump_or_branch, reg_lock} !== 2'b01) begin
            errors++; $display("FAIL buf_second: got jb/lock %b want 01", {jump_or_branch, reg_lock});
        end
        next_cycle();
        #1;
        checks++;
        if ({jump_or_branch, bubble_ex, reg_lock} !== 3'b110 || target !== 32'h0000_0200) begin
            errors++; $display("FAIL buf_release: got jb/bub/lock %b tgt %h want 110 tgt 00000200",
                               {jump_or_branch, bubble_ex, reg_lock}, target);
        end
        next_cycle();
        #1;
        checks++;
        if ({flush_id, jump_or_branch} !== 2'b10) begin
            errors++; $display("FAIL buf_after: got fl/jb %b want 10 (no 300 redirect)", {flush_id, jump_or_branch});
        end
    endtask

    task automatic test_redirect_vs_ldu();
        next_cycle();
        ex_is_load = 1'b1; ex_rd = 5'd12; id_rs1 = 5'd12; id_uses_rs1 = 1'b1;
        br_taken = 1'b1; br_target = 32'h0000_0440;
        #1;
        checks++;
        if ({reg_lock, jump_or_branch, bubble_ex} !== 3'b011 || target !== 32'h0000_0440) begin
            errors++; $display("FAIL redir_over_ldu: got lock/jb/bub %b tgt %h want 011 tgt 00000440",
                               {reg_lock, jump_or_branch, bubble_ex}, target);
        end
        next_cycle();
        #1;
        checks++;
        if ({flush_id, reg_lock} !== 2'b10) begin
            errors++; $display("FAIL redir_over_ldu_next: got fl/lock %b want 10", {flush_id, reg_lock});
        end
    endtask

    task automatic test_mul_and_branch();
        next_cycle();
        ex_is_mul = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0500;
        #1;
        checks++;
        if ({jump_or_branch, reg_lock} !== 2'b10) begin
            errors++; $display("FAIL mulbr_t: got jb/lock %b want 10", {jump_or_branch, reg_lock});
        end
        next_cycle();
        #1;
        checks++;
        if ({reg_lock, ex_hold, flush_id, jump_or_branch} !== 4'b1110) begin
            errors++; $display("FAIL mulbr_t1: got lock/hold/fl/jb %b want 1110", {reg_lock, ex_hold, flush_id, jump_or_branch});
        end
        repeat (3) next_cycle();
    endtask

    task automatic test_back_to_back();
        next_cycle();
        br_taken = 1'b1; br_target = 32'h0000_0600;
        next_cycle();
        br_taken = 1'b1; br_target = 32'h0000_0700;
        #1;
        checks++;
        if ({jump_or_branch, flush_id} !== 2'b11 || target !== 32'h0000_0700) begin
            errors++; $display("FAIL b2b_second: got jb/fl %b tgt %h want 11 tgt 00000700", {jump_or_branch, flush_id}, target);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] outs;
        next_cycle();
        ex_is_mul = 1'b1;
        next_cycle();
        br_taken = 1'b1; br_target = 32'h0000_0800;
        #3;
        rst_n = 1'b0;
        #1;
        outs = {reg_lock, jump_or_branch, bubble_ex, ex_hold, flush_id, |target};
        checks++;
        if (outs !== 6'b0) begin
            errors++; $display("FAIL reset_mid_outputs: got %b want 000000", outs);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({reg_lock, ex_hold, jump_or_branch, bubble_ex} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_release: got lock/hold/jb/bub %b want 0000", {reg_lock, ex_hold, jump_or_branch, bubble_ex});
        end
        next_cycle();
        #1;
        checks++;
        if ({jump_or_branch, flush_id} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_no_redirect: got jb/fl %b want 00", {jump_or_branch, flush_id});
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_branch();
        test_buffered();
        test_redirect_vs_ldu();
        test_mul_and_branch();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
